alu_issue_regfile: RTL

- Upstream stage for the 4-bit Decode_And_Execute ALU: holds a 4-entry x 4-bit register file, accepts 12-bit instructions over a valid/ready handshake and drives the ALU's rs/rt/sel inputs from registers.
- Captures the ALU's combinational rd output one cycle later and writes it back to the destination register.
- Also executes load-immediate instructions locally, so the register file can be seeded without the ALU.

---
 rtl/alu_issue_regfile_pkg.sv | 58 +++++
 rtl/alu_issue_regfile_regfile_4x4.sv | 44 ++++
 rtl/alu_issue_regfile.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_issue_regfile_pkg.sv
// Shared lab constants for the ALU issue stage: ALU operation codes,
// instruction field layout, FSM state encoding and an instruction decoder.
package alu_issue_regfile_pkg;

  localparam int NREG_C = 4;   // registers in the file
  localparam int DW_C   = 4;   // datapath width, equal to the ALU width
  localparam int AW     = 2;   // register address width
  localparam int IW     = 12;  // instruction width

  // ALU operation select codes
  localparam logic [2:0] SEL_ADD     = 3'b000;
  localparam logic [2:0] SEL_SUB     = 3'b001;
  localparam logic [2:0] SEL_AND     = 3'b010;
  localparam logic [2:0] SEL_OR      = 3'b011;
  localparam logic [2:0] SEL_ROTL_RS = 3'b100;
  localparam logic [2:0] SEL_ASR_RT  = 3'b101;
  localparam logic [2:0] SEL_EQ      = 3'b110;
  localparam logic [2:0] SEL_GT      = 3'b111;

  // Instruction field positions
  localparam int LI_BIT   = 11;
  localparam int SEL_MSB  = 10;
  localparam int SEL_LSB  = 8;
  localparam int DST_MSB  = 7;
  localparam int DST_LSB  = 6;
  localparam int SRCS_MSB = 5;
  localparam int SRCS_LSB = 4;
  localparam int SRCT_MSB = 3;
  localparam int SRCT_LSB = 2;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  typedef struct packed {
    logic          is_li;
    logic [2:0]    sel;
    logic [AW-1:0] dst;
    logic [AW-1:0] src_s;
    logic [AW-1:0] src_t;
    logic [3:0]    imm;
  } instr_t;

  // Split a raw instruction word into its fields (both formats at once)
  function automatic instr_t decode(input logic [IW-1:0] w);
    instr_t d;
    d.is_li = w[LI_BIT];
    d.sel   = w[SEL_MSB:SEL_LSB];
    d.dst   = w[DST_MSB:DST_LSB];
    d.src_s = w[SRCS_MSB:SRCS_LSB];
    d.src_t = w[SRCT_MSB:SRCT_LSB];
    d.imm   = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_regfile_regfile_4x4.sv
// Small register file: two combinational operand read ports, one
// combinational debug read port and one synchronous write port.
module regfile_4x4
  import alu_issue_regfile_pkg::*;
#(
  parameter int            NREG     = NREG_C,
  parameter int            DW       = DW_C,
  parameter logic [DW-1:0] REG_INIT = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra_s,
  output logic [DW-1:0] rd_s,
  input  logic [AW-1:0] ra_t,
  output logic [DW-1:0] rd_t,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [NREG-1:0][DW-1:0] regs;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [DW-1:0] q_reg;

    // Per-register storage: load on a write addressed to this entry
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_reg <= REG_INIT;
      end else if (we && (wa == AW'(gi))) begin
        q_reg <= wd;
      end
    end

    assign regs[gi] = q_reg;
  end

  assign rd_s     = regs[ra_s];
  assign rd_t     = regs[ra_t];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_regfile.sv
// Issue stage for the 4-bit ALU: accepts instructions over valid/ready,
// executes load-immediates locally, drives registered operands to the
// external combinational ALU and writes its result back one cycle later.
module alu_issue_regfile
  import alu_issue_regfile_pkg::*;
#(
  parameter int            NREG     = NREG_C,
  parameter int            DW       = DW_C,
  parameter logic [DW-1:0] REG_INIT = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          instr_valid,
  input  logic [11:0]   instr,
  output logic          instr_ready,
  output logic [DW-1:0] alu_rs,
  output logic [DW-1:0] alu_rt,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_rd,
  output logic          wb_valid,
  output logic [1:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [0:0]    state_reg, state_next;
  logic [AW-1:0] dst_reg;
  logic [DW-1:0] alu_rs_reg, alu_rt_reg;
  logic [2:0]    alu_sel_reg;
  logic          wb_valid_reg;
  logic [AW-1:0] wb_addr_reg;
  logic [DW-1:0] wb_data_reg;

  instr_t        dec;
  logic          in_exec;
  logic          accept;
  logic          accept_alu;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [DW-1:0] rd_s, rd_t;

  assign dec         = decode(instr);
  assign in_exec     = (state_reg == ST_EXEC);
  assign instr_ready = ~in_exec;
  assign accept      = instr_valid & instr_ready;
  assign accept_alu  = accept & ~dec.is_li;

  // One write port shared by LI (immediate) and ALU writeback; they can
  // never coincide because nothing is accepted while in EXEC.
  assign rf_we = (accept & dec.is_li) | in_exec;
  assign rf_wa = in_exec ? dst_reg : dec.dst;
  assign rf_wd = in_exec ? alu_rd  : dec.imm;

  regfile_4x4 #(
    .NREG     (NREG),
    .DW       (DW),
    .REG_INIT (REG_INIT)
  ) u_rf (
    .CLK      (CLK),
    .RST      (RST),
    .we       (rf_we),
    .wa       (rf_wa),
    .wd       (rf_wd),
    .ra_s     (dec.src_s),
    .rd_s     (rd_s),
    .ra_t     (dec.src_t),
    .rd_t     (rd_t),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Next-state: an accepted ALU op spends exactly one cycle in EXEC
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept_alu) state_next = ST_EXEC;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Operand/select capture at the accept edge (pre-edge register values)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_rs_reg  <= '0;
      alu_rt_reg  <= '0;
      alu_sel_reg <= '0;
      dst_reg     <= '0;
    end else if (accept_alu) begin
      alu_rs_reg  <= rd_s;
      alu_rt_reg  <= rd_t;
      alu_sel_reg <= dec.sel;
      dst_reg     <= dec.dst;
    end
  end

  // Writeback report: one-cycle pulse, address/data hold between writes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
    end else begin
      wb_valid_reg <= rf_we;
      if (rf_we) begin
        wb_addr_reg <= rf_wa;
        wb_data_reg <= rf_wd;
      end
    end
  end

  assign alu_rs   = alu_rs_reg;
  assign alu_rt   = alu_rt_reg;
  assign alu_sel  = alu_sel_reg;
  assign wb_valid = wb_valid_reg;
  assign wb_addr  = wb_addr_reg;
  assign wb_data  = wb_data_reg;

endmodule
